// File: rtl/conv_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_if
// Brief    : Pixel stream, result stream and coefficient bus for conv_stream_engine.
// Revision : 1.0  initial release
// ============================================================================
interface conv_stream_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
);
    logic [DATA_W-1:0]        i_pixel_data;
    logic                     i_pixel_data_valid;
    logic                     o_data_ready;
    logic [DATA_W-1:0]        o_data;
    logic                     o_data_valid;
    logic                     o_data_last;
    logic                     i_data_ready;
    logic                     i_coef_we;
    logic [3:0]               i_coef_idx;
    logic signed [COEF_W-1:0] i_coef_data;
    logic                     o_intr;

    modport slave (
        input  i_pixel_data, i_pixel_data_valid, i_data_ready,
               i_coef_we, i_coef_idx, i_coef_data,
        output o_data_ready, o_data, o_data_valid, o_data_last, o_intr
    );

    modport master (
        output i_pixel_data, i_pixel_data_valid, i_data_ready,
               i_coef_we, i_coef_idx, i_coef_data,
        input  o_data_ready, o_data, o_data_valid, o_data_last, o_intr
    );
endinterface
`default_nettype wire

// File: rtl/conv_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_engine
// Brief    : 3x3 streaming convolution with line buffers, programmable signed
//            kernel and FWFT output FIFO. CONV_SATURATE_EN clamps results.
// Revision : 1.0  initial release
// ============================================================================
module conv_stream_engine #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int COEF_W     = 8,
    parameter int SHIFT      = 3,
    parameter int FIFO_DEPTH = 32
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst,
    conv_stream_if.slave s_bus
);
    localparam int c_COL_W  = $clog2(IMG_W);
    localparam int c_ROW_W  = $clog2(IMG_H);
    localparam int c_PROD_W = DATA_W + COEF_W + 1;
    localparam int c_SUM_W  = DATA_W + COEF_W + 5;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_ENT_W  = DATA_W + 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);
    localparam logic signed [COEF_W-1:0] c_COEF_UNITY = COEF_W'(1 << SHIFT);

    // ------------------------------------------------------------------
    // Input accept and raster position
    // ------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_win_ok;
    logic                 w_last_pos;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;

    assign w_accept   = s_bus.i_pixel_data_valid && s_bus.o_data_ready;
    assign w_win_ok   = (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
    assign w_last_pos = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and 3x3 window (taps in raster order, 8 = newest pixel)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;
    logic [DATA_W-1:0] r_win [9];

    assign w_lb0_rd = r_lb0[r_col];
    assign w_lb1_rd = r_lb1[r_col];

    // Storage is not reset: the window is only consumed from row 2 onward,
    // by which point every tap holds pixels of the current frame.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r*3]   <= r_win[r*3+1];
                r_win[r*3+1] <= r_win[r*3+2];
            end
            r_win[2]     <= w_lb1_rd;
            r_win[5]     <= w_lb0_rd;
            r_win[8]     <= s_bus.i_pixel_data;
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= s_bus.i_pixel_data;
        end
    end

    // ------------------------------------------------------------------
    // Coefficients. Writes are staged one cycle so a write landing with an
    // accept reaches the multipliers only after that pixel's products.
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0] r_coef [9];
    logic                     r_cw_we;
    logic [3:0]               r_cw_idx;
    logic signed [COEF_W-1:0] r_cw_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cw_we   <= 1'b0;
            r_cw_idx  <= '0;
            r_cw_data <= '0;
            for (int k = 0; k < 9; k++) begin
                r_coef[k] <= (k == 4) ? c_COEF_UNITY : '0;
            end
        end else begin
            r_cw_we   <= s_bus.i_coef_we;
            r_cw_idx  <= s_bus.i_coef_idx;
            r_cw_data <= s_bus.i_coef_data;
            if (r_cw_we && (r_cw_idx < 4'd9)) begin
                r_coef[r_cw_idx] <= r_cw_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic pipeline: products, adder tree, shift/format
    // ------------------------------------------------------------------
    logic                       r_v1, r_v2, r_v3;
    logic                       r_l1, r_l2, r_l3;
    logic signed [c_PROD_W-1:0] r_prod [9];
    logic signed [c_SUM_W-1:0]  w_sum;
    logic signed [c_SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0]          w_res;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_l1 <= 1'b0;
            r_l2 <= 1'b0;
            r_l3 <= 1'b0;
        end else begin
            r_v1 <= w_accept && w_win_ok;
            r_l1 <= w_accept && w_last_pos;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            r_v3 <= r_v2;
            r_l3 <= r_l2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_v1) begin
            for (int k = 0; k < 9; k++) begin
                r_prod[k] <= c_PROD_W'($signed({1'b0, r_win[k]})) * c_PROD_W'(r_coef[k]);
            end
        end
        if (r_v2) begin
            r_sum <= w_sum;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + c_SUM_W'(r_prod[k]);
        end
    end

`ifdef CONV_SATURATE_EN
    localparam logic signed [c_SUM_W-1:0] c_PIX_MAX = c_SUM_W'((1 << DATA_W) - 1);
    logic signed [c_SUM_W-1:0] w_shifted;

    assign w_shifted = r_sum >>> SHIFT;

    always_comb begin
        if (w_shifted[c_SUM_W-1]) begin
            w_res = '0;
        end else if (w_shifted > c_PIX_MAX) begin
            w_res = '1;
        end else begin
            w_res = w_shifted[DATA_W-1:0];
        end
    end
`else
    assign w_res = DATA_W'(r_sum >>> SHIFT);
`endif

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through), entry = {last, data}
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic [c_ENT_W-1:0] w_head;
    logic [1:0]         w_inflight;
    logic [c_CNT_W-1:0] w_occupancy;
    logic               r_intr;

    assign w_push     = r_v3;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && s_bus.i_data_ready;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_l3, w_res};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_intr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_intr <= w_pop && w_head[DATA_W];
        end
    end

    // Every result still in the pipeline already owns a FIFO slot, so
    // admission is gated on stored plus in-flight results.
    assign w_inflight  = 2'(r_v1) + 2'(r_v2) + 2'(r_v3);
    assign w_occupancy = r_count + c_CNT_W'(w_inflight);

    assign s_bus.o_data_ready = (w_occupancy < c_CNT_W'(FIFO_DEPTH));
    assign s_bus.o_data_valid = w_nonempty;
    assign s_bus.o_data       = w_nonempty ? w_head[DATA_W-1:0] : '0;
    assign s_bus.o_data_last  = w_nonempty && w_head[DATA_W];
    assign s_bus.o_intr       = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_stream_engine
// Brief    : Randomised self-checking bench for conv_stream_engine against a
//            frame-level convolution model.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_stream_engine;
    localparam int c_DATA_W = 8;
    localparam int c_COEF_W = 8;
    localparam int c_IMG_W  = 8;
    localparam int c_IMG_H  = 4;
    localparam int c_SHIFT  = 3;
    localparam int c_DEPTH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_stream_if #(.DATA_W(c_DATA_W), .COEF_W(c_COEF_W)) bus ();

    conv_stream_engine #(
        .DATA_W(c_DATA_W), .IMG_W(c_IMG_W), .IMG_H(c_IMG_H),
        .COEF_W(c_COEF_W), .SHIFT(c_SHIFT), .FIFO_DEPTH(c_DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int ds_mode = 1;              // 0 stall, 1 always ready, 2 random
    logic [8:0] obs[$];
    logic [8:0] exp_q[$];
    int frame [c_IMG_H][c_IMG_W];
    int coef [9];
    int outstanding = 0, pix_idx = 0, max_out = 0;
    int ready_bad = 0, intr_cnt = 0, intr_bad = 0;
    logic prev_last_pop = 1'b0;

    // Result-level bookkeeping: results owed = valid windows accepted - pops
    always @(negedge clk) begin
        if (rst) begin
            outstanding   = 0;
            pix_idx       = 0;
            prev_last_pop = 1'b0;
        end else begin
            if (bus.o_data_ready !== (outstanding < c_DEPTH)) ready_bad++;
            if (bus.o_intr !== prev_last_pop) intr_bad++;
            if (bus.o_intr === 1'b1) intr_cnt++;
            prev_last_pop = bus.o_data_valid && bus.i_data_ready && bus.o_data_last;
            if (bus.i_pixel_data_valid && bus.o_data_ready) begin
                if ((pix_idx / c_IMG_W) >= 2 && (pix_idx % c_IMG_W) >= 2) outstanding++;
                pix_idx = (pix_idx + 1) % (c_IMG_W * c_IMG_H);
            end
            if (bus.o_data_valid && bus.i_data_ready) begin
                obs.push_back({bus.o_data_last, bus.o_data});
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    initial begin
        bus.i_data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ds_mode)
                0:       bus.i_data_ready = 1'b0;
                1:       bus.i_data_ready = 1'b1;
                default: bus.i_data_ready = 1'($urandom % 2);
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic write_coef(input int idx, input int val);
        bus.i_coef_we   = 1'b1;
        bus.i_coef_idx  = 4'(idx);
        bus.i_coef_data = 8'(val);
        @(posedge clk); #1;
        bus.i_coef_we   = 1'b0;
        coef[idx] = val;
    endtask

    task automatic set_coefs(input int c[9]);
        for (int k = 0; k < 9; k++) write_coef(k, c[k]);
        idle(2);
    endtask

    task automatic push_pixel(input int p);
        int t;
        t = 0;
        bus.i_pixel_data       = 8'(p);
        bus.i_pixel_data_valid = 1'b1;
        @(negedge clk);
        while (bus.o_data_ready !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        checks++;
        if (bus.o_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout: o_data_ready=%b required=1", bus.o_data_ready);
        end
        @(posedge clk); #1;
        bus.i_pixel_data_valid = 1'b0;
    endtask

    task automatic send_frame(input int f[c_IMG_H][c_IMG_W], input bit gaps);
        for (int r = 0; r < c_IMG_H; r++)
            for (int c = 0; c < c_IMG_W; c++) begin
                if (gaps && ($urandom % 4) == 0) idle(1 + $urandom % 2);
                push_pixel(f[r][c]);
            end
    endtask

    // Valid-only 3x3 convolution of a whole frame, straight from the rules
    task automatic build_expected(input int f[c_IMG_H][c_IMG_W]);
        int sum, sh, res;
        for (int r = 2; r < c_IMG_H; r++)
            for (int c = 2; c < c_IMG_W; c++) begin
                sum = 0;
                for (int k = 0; k < 9; k++) sum += coef[k] * f[r-2+k/3][c-2+k%3];
                sh = sum >>> c_SHIFT;
`ifdef CONV_SATURATE_EN
                res = (sh < 0) ? 0 : (sh > 255) ? 255 : sh;
`else
                res = sh & 255;
`endif
                exp_q.push_back({(r == c_IMG_H-1 && c == c_IMG_W-1) ? 1'b1 : 1'b0, 8'(res)});
            end
    endtask

    task automatic check_outputs(input string name);
        int t;
        t = 0;
        while (obs.size() < exp_q.size() && t < 3000) begin @(posedge clk); #1; t++; end
        idle(8);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d outputs, expected %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_out[%0d]: got last=%b data=%0d, expected last=%b data=%0d",
                         name, i, obs[i][8], obs[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic clear_queues();
        obs.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.o_data_valid !== 1'b0 || bus.o_data_last !== 1'b0 || bus.o_intr !== 1'b0 ||
            bus.o_data !== 8'd0 || bus.o_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_outputs: valid=%b last=%b intr=%b data=%0d ready=%b, required 0 0 0 0 1",
                     name, bus.o_data_valid, bus.o_data_last, bus.o_intr, bus.o_data, bus.o_data_ready);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        coef = '{0, 0, 0, 0, 8, 0, 0, 0, 0};
        clear_queues();
    endtask

    task automatic test_reset();
        apply_reset();
        idle(3);
        checks++;
        if (bus.o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_valid: got %b required 0", bus.o_data_valid);
        end
    endtask

    task automatic test_identity();
        int i0;
        ds_mode = 1;
        for (int r = 0; r < c_IMG_H; r++)
            for (int c = 0; c < c_IMG_W; c++) frame[r][c] = r * 8 + c;
        build_expected(frame);
        i0 = intr_cnt;
        send_frame(frame, 1'b0);
        check_outputs("identity");
        checks++;
        if (obs.size() < 12 || obs[0] !== 9'd9 || obs[5] !== 9'd14 || obs[6] !== 9'd17 || obs[11] !== {1'b1, 8'd22}) begin
            errors++;
            $display("FAIL identity_ramp: got size=%0d first=%0d last_entry=%h, required 12, 9, 116",
                     obs.size(), obs.size() > 0 ? obs[0] : 9'd0, obs.size() > 11 ? obs[11] : 9'd0);
        end
        checks++;
        if (intr_cnt - i0 != 1) begin
            errors++;
            $display("FAIL identity_intr: got %0d pulses required 1", intr_cnt - i0);
        end
        clear_queues();
    endtask

    task automatic run_const_frame(input string name, input int c[9], input int pix, input int required);
        set_coefs(c);
        for (int r = 0; r < c_IMG_H; r++)
            for (int col = 0; col < c_IMG_W; col++) frame[r][col] = pix;
        build_expected(frame);
        send_frame(frame, 1'b1);
        check_outputs(name);
        checks++;
        if (obs.size() == 0 || obs[0][7:0] !== 8'(required)) begin
            errors++;
            $display("FAIL %s_value: got %0d required %0d", name, obs.size() > 0 ? obs[0][7:0] : 8'd0, required);
        end
        clear_queues();
    endtask

    task automatic test_kernels();
        ds_mode = 2;
        run_const_frame("box", '{1, 1, 1, 1, 1, 1, 1, 1, 1}, 80, 90);
`ifdef CONV_SATURATE_EN
        run_const_frame("saturation", '{0, 0, 0, 0, 64, 0, 0, 0, 0}, 200, 255);
        run_const_frame("negative", '{0, 0, 0, 0, -8, 0, 0, 0, 0}, 10, 0);
`else
        run_const_frame("saturation", '{0, 0, 0, 0, 64, 0, 0, 0, 0}, 200, 64);
        run_const_frame("negative", '{0, 0, 0, 0, -8, 0, 0, 0, 0}, 10, 246);
`endif
    endtask

    task automatic test_back_to_back();
        int cv[9];
        int fb [c_IMG_H][c_IMG_W];
        int i0;
        logic signed [7:0] s;
        ds_mode = 2;
        for (int k = 0; k < 9; k++) begin s = 8'($urandom); cv[k] = s; end
        set_coefs(cv);
        for (int r = 0; r < c_IMG_H; r++)
            for (int c = 0; c < c_IMG_W; c++) begin
                frame[r][c] = $urandom_range(0, 255);
                fb[r][c]    = $urandom_range(0, 255);
            end
        build_expected(frame);
        build_expected(fb);
        i0 = intr_cnt;
        send_frame(frame, 1'b0);
        send_frame(fb, 1'b0);
        check_outputs("back_to_back");
        checks++;
        if (intr_cnt - i0 != 2) begin
            errors++;
            $display("FAIL back_to_back_intr: got %0d pulses required 2", intr_cnt - i0);
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        int t;
        apply_reset();
        ds_mode = 0;
        idle(2);
        max_out = 0;
        for (int r = 0; r < c_IMG_H; r++)
            for (int c = 0; c < c_IMG_W; c++) frame[r][c] = $urandom_range(0, 255);
        build_expected(frame);
        fork
            send_frame(frame, 1'b0);
        join_none
        t = 0;
        @(negedge clk);
        while (bus.o_data_ready !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (bus.o_data_ready !== 1'b0 || outstanding != c_DEPTH) begin
            errors++;
            $display("FAIL bp_drop: ready=%b held=%0d, required ready=0 held=%0d", bus.o_data_ready, outstanding, c_DEPTH);
        end
        idle(12);
        checks++;
        if (bus.o_data_ready !== 1'b0 || bus.o_data_valid !== 1'b1 || obs.size() != 0 || max_out != c_DEPTH) begin
            errors++;
            $display("FAIL bp_hold: ready=%b valid=%b popped=%0d peak=%0d, required 0 1 0 %0d",
                     bus.o_data_ready, bus.o_data_valid, obs.size(), max_out, c_DEPTH);
        end
        ds_mode = 1;
        wait fork;
        check_outputs("backpressure");
        clear_queues();
    endtask

    task automatic test_reset_midframe();
        ds_mode = 1;
        set_coefs('{1, 1, 1, 1, 1, 1, 1, 1, 1});
        for (int r = 0; r < c_IMG_H; r++)
            for (int c = 0; c < c_IMG_W; c++) frame[r][c] = r * 8 + c;
        for (int i = 0; i < 20; i++) push_pixel(frame[i / c_IMG_W][i % c_IMG_W]);
        apply_reset();
        build_expected(frame);
        send_frame(frame, 1'b1);
        check_outputs("reset_midframe");
        clear_queues();
    endtask

    task automatic test_invariants();
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL ready_rule: %0d cycles where o_data_ready disagreed with held results", ready_bad);
        end
        checks++;
        if (intr_bad != 0) begin
            errors++;
            $display("FAIL intr_timing: %0d misaligned o_intr cycles, required 0", intr_bad);
        end
        checks++;
        if (max_out > c_DEPTH) begin
            errors++;
            $display("FAIL fifo_bound: peak held results %0d exceeds %0d", max_out, c_DEPTH);
        end
    endtask

    initial begin
        bus.i_pixel_data       = '0;
        bus.i_pixel_data_valid = 1'b0;
        bus.i_coef_we          = 1'b0;
        bus.i_coef_idx         = '0;
        bus.i_coef_data        = '0;
        idle(2);
        test_reset();
        test_identity();
        test_kernels();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv_stream_engine.md
# conv_stream_engine

Parametrised 3x3 streaming convolution engine: accepts raster-order pixels, builds the 3x3 window internally from two line buffers, applies a runtime-programmable signed kernel, and delivers results through an internal output FIFO with tlast and a frame-done interrupt. It is the next generation of the convolution top level. It adds:
- configurable image size, pixel width and FIFO depth
- loadable coefficients
- exact backpressure that never overflows the FIFO

## Interface
- DATA_W, 8: pixel width (unsigned)
- IMG_W, 512: pixels per line (≥3)
- IMG_H, 512: lines per frame (≥3)
- COEF_W, 8: signed coefficient width
- SHIFT, 3: arithmetic right shift applied to the kernel sum
- FIFO_DEPTH, 32: output FIFO entries (power of two, ≥8)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_pixel_data  in  DATA_W  input pixel
- i_pixel_data_valid  in  1  input valid
- o_data_ready  out  1  input ready
- o_data  out  DATA_W  output pixel
- o_data_valid  out  1  output valid
- o_data_last  out  1  last output pixel of frame
- i_data_ready  in  1  downstream ready
- i_coef_we  in  1  coefficient write strobe
- i_coef_idx  in  4  kernel tap 0..8, raster order (0 = top-left, 4 = centre)
- i_coef_data  in  COEF_W  signed coefficient
- o_intr  out  1  one-cycle frame-done pulse

## Operation
- **Input accept:** an input is accepted on an edge where i_pixel_data_valid && o_data_ready.
- **Counters:** col counts 0..IMG_W-1 and row counts 0..IMG_H-1. Both wrap to 0 after (IMG_H-1, IMG_W-1); no idle gap between frames is required.
- **Line buffers:** two line buffers, each IMG_W deep, plus a 3x3 register window shift on every accepted pixel.
- **Window validity:** the window is valid when row ≥ 2 && col ≥ 2 (valid-only convolution). Output is therefore (IMG_W-2)x(IMG_H-2) pixels per frame. No padding is applied.
- **Pipeline stages:**
  - P1: nine products, pixel zero-extended to signed × coefficient.
  - P2: adder-tree sum, SUM_W = DATA_W+COEF_W+5.
  - P3: arithmetic shift right by SHIFT, then saturate or wrap (see Configuration), then FIFO write.
- **tlast:** the output for input (IMG_H-1, IMG_W-1) carries last=1. It is stored in the FIFO alongside the data (DATA_W+1 wide).
- **Interrupt:** o_intr pulses for one cycle on the edge the last=1 pixel is popped (o_data_valid && i_data_ready && o_data_last).
- **Coefficients:**
  - Writes take effect for any window multiplied on a later edge. A write coincident with an accept does not affect that pixel's P1.
  - Reset value: tap 4 = 2^SHIFT, all other taps 0 (identity).
  - Software changes coefficients between frames only; a mid-frame write is honoured, not blocked.
- **Backpressure:** o_data_ready = (fifo_count + inflight) < FIFO_DEPTH, where inflight is the number of valid P1..P3 stages.
  - The FIFO therefore never overflows.
  - A FIFO write while full is impossible by construction; the bench asserts this.
- **FIFO behaviour:** the FIFO is first-word-fall-through. Simultaneous push and pop when full or empty is legal; count is unchanged when both occur.

## Timing
- **Reset:**
  - Outputs: o_data_valid=0, o_data_last=0, o_intr=0, o_data=0, o_data_ready=1 on the cycle after i_rst sampled high.
  - Clears counters, pipeline valids, FIFO pointers and coefficients (to identity).
  - Line-buffer RAM contents are not cleared. They are don't-care because the window is invalid until row 2.
  - Reset mid-frame discards all in-flight and buffered outputs; the next accepted pixel is (0,0).
- **Latency:** pixel accepted at edge E completes P1 at E+1, P2 at E+2 and the FIFO write at E+3. With the FIFO empty, o_data_valid is high in the cycle after E+3.
- **Throughput:** one pixel per cycle when downstream is always ready.
- **Output hold:** o_data/o_data_last are stable while o_data_valid && !i_data_ready.
- **Ready timing:** o_data_ready is combinational from registered state only, with no path from i_pixel_data_valid.

## Configuration
- CONV_SATURATE_EN defined: the shifted sum is clamped to [0, 2^DATA_W-1].
- Not defined: o_data is the low DATA_W bits of the shifted sum (two's-complement wrap).

## Test plan
- **Identity:** IMG_W=8, IMG_H=4, reset coefficients, ramp input p=row*8+col → exactly 12 outputs: 9..14 then 17..22. last=1 only on 22. o_intr pulses once, one cycle after 22 pops.
- **Box:** all nine taps = 1, SHIFT=3, constant input 80 → every output = 90 (720>>3).
- **Saturation:** tap 4 = 64, others 0, SHIFT=3, input 200. With CONV_SATURATE_EN → 255. Without → (1600)&0xFF = 64.
- **Negative:** tap 4 = -8, input 10, SHIFT=3. With the macro → 0. Without → 246 (-10 wrapped).
- **Backpressure:** FIFO_DEPTH=8, i_data_ready=0, continuous valid input.
  - o_data_ready drops once count+inflight reaches 8.
  - Exactly 8 results are buffered with no overflow.
  - Releasing ready drains them in order with no loss or duplication.
- **Reset mid-frame:** assert i_rst after 20 inputs → outputs go idle next cycle. A full fresh frame then produces exactly 12 correct outputs with no stale data.
